timer_scheduler: RTL and testbench

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler_if.sv | 29 ++
 rtl/timer_scheduler.sv | 116 +++++++++++
 tb/tb_timer_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_scheduler_if.sv
// Bundle between the timer scheduler, its two requesters and the shared countdown timer.
// The slave side is the scheduler; the master side is the requesters plus the timer.
interface timer_scheduler_if #(
  parameter int MAX_MS = 2047
);
  localparam int W = $clog2(MAX_MS);

  logic [1:0]   req;
  logic [W-1:0] req_ms0;
  logic [W-1:0] req_ms1;
  logic [1:0]   abort;
  logic [1:0]   grant;
  logic [1:0]   done;
  logic         busy;
  logic         tmr_stop;
  logic         tmr_enable;
  logic [W-1:0] tmr_start_value;
  logic [W-1:0] tmr_value;

  modport master (
    output req, req_ms0, req_ms1, abort, tmr_value,
    input  grant, done, busy, tmr_stop, tmr_enable, tmr_start_value
  );

  modport slave (
    input  req, req_ms0, req_ms1, abort, tmr_value,
    output grant, done, busy, tmr_stop, tmr_enable, tmr_start_value
  );
endinterface

// File: rtl/timer_scheduler.sv
// Round-robin arbiter that hands one shared countdown timer to two requesters.
// Every output is a register written by the single state machine below.
module timer_scheduler #(
  parameter int MAX_MS = 2047
) (
  input  logic               clk,
  input  logic               rst_n,
  timer_scheduler_if.slave   bus
);
  localparam int W = $clog2(MAX_MS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state;
  logic         owner;
  logic         last_grant;
  logic [W-1:0] ms_q;
  logic [1:0]   grant_q;
  logic [1:0]   done_q;
  logic         busy_q;
  logic         stop_q;
  logic         enable_q;

  logic         winner;
  logic         owner_abort;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // A tie goes to whoever was not served last; a single request wins outright.
  always_comb begin
    winner = bus.req[1];
    if (bus.req == 2'b11) winner = ~last_grant;
  end

  assign owner_abort = bus.abort[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ms_q       <= '0;
      grant_q    <= 2'b00;
      done_q     <= 2'b00;
      busy_q     <= 1'b0;
      stop_q     <= 1'b1;
      enable_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            state   <= LOAD;
            owner   <= winner;
            ms_q    <= winner ? bus.req_ms1 : bus.req_ms0;
            grant_q <= onehot(winner);
            busy_q  <= 1'b1;
          end
        end

        LOAD: begin
          if (owner_abort) begin
            state      <= IDLE;
            last_grant <= owner;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
          end else begin
            state    <= RUN;
            stop_q   <= 1'b0;
            enable_q <= 1'b1;
          end
        end

        // An abort arriving together with expiry still cancels the interval.
        RUN: begin
          if (owner_abort) begin
            state      <= IDLE;
            last_grant <= owner;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
            stop_q     <= 1'b1;
            enable_q   <= 1'b0;
          end else if (bus.tmr_value == '0) begin
            state    <= DONE;
            done_q   <= onehot(owner);
            stop_q   <= 1'b1;
            enable_q <= 1'b0;
          end
        end

        DONE: begin
          state      <= IDLE;
          last_grant <= owner;
          done_q     <= 2'b00;
          grant_q    <= 2'b00;
          busy_q     <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant           = grant_q;
  assign bus.done            = done_q;
  assign bus.busy            = busy_q;
  assign bus.tmr_stop        = stop_q;
  assign bus.tmr_enable      = enable_q;
  assign bus.tmr_start_value = ms_q;
endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: a millisecond countdown timer (4 clocks per ms), an
// interval-level reference model compared every cycle, directed scenarios and random traffic.
module tb_timer_scheduler;
  localparam int MAX_MS = 2047;
  localparam int W      = 11;
  localparam int CPM    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  timer_scheduler_if #(.MAX_MS(MAX_MS)) bus();

  timer_scheduler #(.MAX_MS(MAX_MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Countdown timer: stop reloads, enable decrements once every CPM clocks down to zero.
  int pre;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tmr_value <= '0;
      pre           <= 0;
    end else if (bus.tmr_stop) begin
      bus.tmr_value <= bus.tmr_start_value;
      pre           <= 0;
    end else if (bus.tmr_enable) begin
      if (pre == CPM - 1) begin
        pre <= 0;
        if (bus.tmr_value != '0) bus.tmr_value <= bus.tmr_value - W'(1);
      end else begin
        pre <= pre + 1;
      end
    end
  end

  // Reference model: owner of the current interval and how many cycles it has held the grant.
  // An interval of ms milliseconds expires in the RUN cycle 4*ms+1 after the grant cycle.
  int           m_owner   = -1;
  int           m_cyc     = 0;
  int           m_last    = 1;
  bit           m_in_done = 1'b0;
  logic [W-1:0] m_ms      = '0;

  task automatic model_reset();
    m_owner   = -1;
    m_cyc     = 0;
    m_last    = 1;
    m_in_done = 1'b0;
    m_ms      = '0;
  endtask

  task automatic model_step();
    int w;
    if (m_owner < 0) begin
      if (bus.req != 2'b00) begin
        if (bus.req == 2'b11) w = 1 - m_last;
        else                  w = (bus.req == 2'b10) ? 1 : 0;
        m_owner   = w;
        m_ms      = (w == 1) ? bus.req_ms1 : bus.req_ms0;
        m_cyc     = 0;
        m_in_done = 1'b0;
      end
    end else if (m_in_done) begin
      m_last    = m_owner;
      m_owner   = -1;
      m_in_done = 1'b0;
    end else if (bus.abort[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_cyc == CPM * int'(m_ms) + 1) begin
      m_in_done = 1'b1;
    end else begin
      m_cyc++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    int e_grant, e_done, e_busy, e_stop, e_en, e_sv;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_grant = 0; e_done = 0; e_busy = 0; e_stop = 1; e_en = 0; e_sv = 0;
      end else begin
        e_grant = (m_owner < 0) ? 0 : (1 << m_owner);
        e_done  = (m_owner >= 0 && m_in_done) ? (1 << m_owner) : 0;
        e_busy  = (m_owner >= 0) ? 1 : 0;
        e_stop  = (m_owner < 0 || m_cyc == 0 || m_in_done) ? 1 : 0;
        e_en    = 1 - e_stop;
        e_sv    = int'(m_ms);
      end
      chk("cyc_grant", int'(bus.grant), e_grant);
      chk("cyc_done", int'(bus.done), e_done);
      chk("cyc_busy", int'(bus.busy), e_busy);
      chk("cyc_tmr_stop", int'(bus.tmr_stop), e_stop);
      chk("cyc_tmr_enable", int'(bus.tmr_enable), e_en);
      chk("cyc_start_value", int'(bus.tmr_start_value), e_sv);
      chk("cyc_grant_onehot0", int'($onehot0(bus.grant)), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with grant held until done is seen; drops req once granted.
  task automatic serve(input string name, input int budget, output int n, output int dn);
    n  = 0;
    dn = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.grant != 2'b00) begin
        n++;
        bus.req = 2'b00;
      end
      if (bus.done != 2'b00) begin
        dn = int'(bus.done);
        break;
      end
    end
    if (dn < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_grant(input string name);
    int ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.grant != 2'b00) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_grant_seen"}, ok, 1);
    bus.req = 2'b00;
  endtask

  task automatic wait_idle();
    int ok = 0;
    bus.req = 2'b00;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
  endtask

  initial begin
    int n, dn, owners[3], k;
    logic [1:0] prev;
    bus.req = 2'b00; bus.abort = 2'b00; bus.req_ms0 = '0; bus.req_ms1 = '0;

    // Reset values
    @(negedge clk);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tmr_stop", int'(bus.tmr_stop), 1);
    chk("rst_start_value", int'(bus.tmr_start_value), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Tie: requester 0 first, then 1, then 0
    bus.req_ms0 = 2; bus.req_ms1 = 5; bus.req = 2'b11;
    k = 0; prev = 2'b00;
    for (int i = 0; i < 400 && k < 3; i++) begin
      @(negedge clk);
      if (prev == 2'b00 && bus.grant != 2'b00) begin
        owners[k] = (bus.grant == 2'b10) ? 1 : 0;
        k++;
      end
      prev = bus.grant;
    end
    chk("tie_count", k, 3);
    chk("tie_first", owners[0], 0);
    chk("tie_second", owners[1], 1);
    chk("tie_third", owners[2], 0);
    wait_idle();
    tick();

    // Single request, 3 ms: LOAD + 13 RUN + DONE = done in the 15th granted cycle
    bus.req_ms0 = 3; bus.req = 2'b01;
    serve("single", 200, n, dn);
    chk("single_grant_cycles", n, 15);
    chk("single_done_bits", dn, 1);
    @(negedge clk);
    chk("single_busy_after", int'(bus.busy), 0);
    chk("single_done_after", int'(bus.done), 0);
    tick();

    // Zero interval: LOAD, one RUN, DONE
    bus.req_ms0 = 0; bus.req = 2'b01;
    serve("zero", 50, n, dn);
    chk("zero_grant_cycles", n, 3);
    chk("zero_done_bits", dn, 1);
    tick();

    // Owner abort 20 cycles into RUN
    bus.req_ms1 = 100; bus.req = 2'b10;
    wait_grant("abort");
    repeat (20) tick();
    bus.abort = 2'b10;
    tick();
    bus.abort = 2'b00;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_grant", int'(bus.grant), 0);
    @(negedge clk);
    chk("abort_tmr_stop", int'(bus.tmr_stop), 1);
    tick();

    // Non-owner abort is ignored: 2 ms -> done in the 11th granted cycle
    bus.req_ms0 = 2; bus.req = 2'b01;
    n = 0; dn = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.grant != 2'b00) begin
        n++;
        bus.req = 2'b00;
      end
      bus.abort = (n == 5) ? 2'b10 : 2'b00;
      if (bus.done != 2'b00) begin
        dn = int'(bus.done);
        break;
      end
    end
    bus.abort = 2'b00;
    chk("nonowner_grant_cycles", n, 11);
    chk("nonowner_done_bits", dn, 1);
    tick(); tick();

    // Abort coincident with tmr_value==0: no done
    bus.req_ms0 = 1; bus.req = 2'b01;
    wait_grant("collide");
    repeat (5) @(posedge clk);
    #1 bus.abort = 2'b01;
    @(negedge clk);
    chk("collide_tmr_zero", int'(bus.tmr_value), 0);
    chk("collide_busy_before", int'(bus.busy), 1);
    tick();
    bus.abort = 2'b00;
    @(negedge clk);
    chk("collide_done", int'(bus.done), 0);
    chk("collide_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("collide_done_later", int'(bus.done), 0);
    tick();

    // Asynchronous reset in the middle of a long interval
    bus.req_ms1 = 11'd2047; bus.req = 2'b10;
    wait_grant("rstmid");
    repeat (10) tick();
    @(negedge clk);
    chk("rstmid_enable_before", int'(bus.tmr_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_grant", int'(bus.grant), 0);
    chk("rstmid_done", int'(bus.done), 0);
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_tmr_stop", int'(bus.tmr_stop), 1);
    chk("rstmid_tmr_enable", int'(bus.tmr_enable), 0);
    chk("rstmid_start_value", int'(bus.tmr_start_value), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 2'($urandom_range(0, 3));
      bus.req_ms0 = W'($urandom_range(0, 5));
      bus.req_ms1 = W'($urandom_range(0, 5));
      bus.abort   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end
    bus.abort = 2'b00;
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
